muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, alongside the main ALU that the ALU control unit drives.
- Accepts one M-extension operation (funct7 = 0000001, R-format) from the ID/EX register.
- Computes the result with a 1-bit-per-cycle shift-add / restoring-divide datapath.
- Holds the pipeline via stall_o until the result is ready for the EX/MEM register.

---
 rtl/muldiv_unit_pkg.sv | 50 +++++
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit_negate.sv | 14 +
 rtl/muldiv_unit.sv | 214 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 / funct7 codes of the M extension
//   - FSM state encoding
//   - helpers deciding which operands are treated as signed
package muldiv_unit_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    function automatic logic signed_a(input logic [2:0] f3);
        logic s;
        case (f3)
            F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
            default:                            s = 1'b0;
        endcase
        return s;
    endfunction

    // rs2 is signed for MULH, DIV and REM.
    function automatic logic signed_b(input logic [2:0] f3);
        logic s;
        case (f3)
            F3_MULH, F3_DIV, F3_REM: s = 1'b1;
            default:                 s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
//   valid_i / flush_i : op present / abort from the pipeline
//   funct3_i          : M-extension operation select
//   op_a_i / op_b_i   : forwarded rs1 / rs2 values
//   busy_o / stall_o  : unit occupied / freeze front end
//   done_o / result_o : one-cycle completion pulse with result
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid_i;
    logic            flush_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            busy_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, flush_i, funct3_i, op_a_i, op_b_i,
        input  busy_o, stall_o, done_o, result_o
    );

    modport slave (
        input  valid_i, flush_i, funct3_i, op_a_i, op_b_i,
        output busy_o, stall_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_unit_negate.sv
// Conditional two's-complement negation, used both to take operand magnitudes
// and to restore the sign of the final product / quotient / remainder.
//   val_i : input value
//   neg_i : 1 = negate, 0 = pass through
//   val_o : result
module muldiv_unit_negate #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);
    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit sitting beside the EX-stage ALU.
// One bit per cycle: shift-add multiply, restoring divide. Operands are
// converted to magnitudes at accept and the sign is restored in FIX.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   md_io : request/response bundle (slave side)
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave md_io
);
    localparam int unsigned      CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0]  CntLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0]  AllOnes = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        funct3_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic [XLEN-1:0]   a_abs_q;
    logic [XLEN-1:0]   b_abs_q;
    logic [2*XLEN-1:0] prod_q;   // {high accumulator, remaining multiplier bits}
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quot_q;   // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0]   result_q;

    // ---------------------------------------------------------------- accept
    logic            accept;
    logic            sign_a_in;
    logic            sign_b_in;
    logic [XLEN-1:0] a_abs_in;
    logic [XLEN-1:0] b_abs_in;
    logic            div_by_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_result;

    assign accept    = (state_q == MD_IDLE) && md_io.valid_i && !md_io.flush_i;
    assign sign_a_in = signed_a(md_io.funct3_i) & md_io.op_a_i[XLEN-1];
    assign sign_b_in = signed_b(md_io.funct3_i) & md_io.op_b_i[XLEN-1];

    muldiv_unit_negate #(.W(XLEN)) u_abs_a (
        .val_i (md_io.op_a_i),
        .neg_i (sign_a_in),
        .val_o (a_abs_in)
    );

    muldiv_unit_negate #(.W(XLEN)) u_abs_b (
        .val_i (md_io.op_b_i),
        .neg_i (sign_b_in),
        .val_o (b_abs_in)
    );

    // Divide by zero and signed overflow finish without iterating.
    assign div_by_zero = is_div(md_io.funct3_i) && (md_io.op_b_i == '0);
    assign div_ovf     = md_io.funct3_i[2] && !md_io.funct3_i[0] &&
                         (md_io.op_a_i == MinNeg) && (md_io.op_b_i == AllOnes);
    assign special     = div_by_zero || div_ovf;

    always_comb begin
        special_result = '0;
        if (div_by_zero) begin
            special_result = md_io.funct3_i[1] ? md_io.op_a_i : AllOnes;
        end else if (div_ovf) begin
            special_result = md_io.funct3_i[1] ? '0 : MinNeg;
        end
    end

    // ------------------------------------------------------------- iteration
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quot_step;

    always_comb begin
        // Multiply: add |a| to the high half when the current multiplier bit
        // is set, then shift the whole accumulator right by one.
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{prod_q[0]}} & a_abs_q};
        prod_step = {mul_sum, prod_q[XLEN-1:1]};

        // Divide: bring in the next dividend bit and try subtracting |b|;
        // the extra top bit of the trial is the borrow.
        div_shift = {rem_q, quot_q[XLEN-1]};
        div_trial = div_shift - {1'b0, b_abs_q};
        if (!div_trial[XLEN]) begin
            rem_step  = div_trial[XLEN-1:0];
            quot_step = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step  = div_shift[XLEN-1:0];
            quot_step = {quot_q[XLEN-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------ sign fixup
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    muldiv_unit_negate #(.W(2*XLEN)) u_fix_prod (
        .val_i (prod_q),
        .neg_i (sign_a_q ^ sign_b_q),
        .val_o (prod_fix)
    );

    muldiv_unit_negate #(.W(XLEN)) u_fix_quot (
        .val_i (quot_q),
        .neg_i (sign_a_q ^ sign_b_q),
        .val_o (quot_fix)
    );

    // Remainder takes the sign of the dividend.
    muldiv_unit_negate #(.W(XLEN)) u_fix_rem (
        .val_i (rem_q),
        .neg_i (sign_a_q),
        .val_o (rem_fix)
    );

    always_comb begin
        fix_result = '0;
        if (funct3_q[2]) begin
            fix_result = funct3_q[1] ? rem_fix : quot_fix;
        end else if (funct3_q[1:0] == 2'b00) begin
            fix_result = prod_fix[XLEN-1:0];
        end else begin
            fix_result = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_abs_q  <= '0;
            b_abs_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        funct3_q <= md_io.funct3_i;
                        sign_a_q <= sign_a_in;
                        sign_b_q <= sign_b_in;
                        a_abs_q  <= a_abs_in;
                        b_abs_q  <= b_abs_in;
                        cnt_q    <= '0;
                        prod_q   <= {{XLEN{1'b0}}, b_abs_in};
                        rem_q    <= '0;
                        quot_q   <= a_abs_in;
                        if (special) begin
                            result_q <= special_result;
                            state_q  <= MD_DONE;
                        end else begin
                            state_q  <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (md_io.flush_i) begin
                        state_q <= MD_IDLE;
                    end else begin
                        if (funct3_q[2]) begin
                            rem_q  <= rem_step;
                            quot_q <= quot_step;
                        end else begin
                            prod_q <= prod_step;
                        end
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == CntLast) begin
                            state_q <= MD_FIX;
                        end
                    end
                end
                MD_FIX: begin
                    if (md_io.flush_i) begin
                        state_q <= MD_IDLE;
                    end else begin
                        result_q <= fix_result;
                        state_q  <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    // Result already committed; flush no longer applies.
                    state_q <= MD_IDLE;
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    assign md_io.busy_o   = (state_q != MD_IDLE);
    assign md_io.done_o   = (state_q == MD_DONE);
    assign md_io.result_o = result_q;
    assign md_io.stall_o  = accept || (state_q == MD_CALC) || (state_q == MD_FIX);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the stimulus process pushes the expected
// result of each issued op; a monitor pops and compares on every done_o.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) md ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .md_io (md)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] last_result;
    logic [31:0] mon_exp;
    string       mon_name;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && md.done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1 result 0x%08h, expected no completion",
                         md.result_o);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, md.result_o, mon_exp);
            end
        end
    end

    // Issue one op and follow it to completion; checks latency and stall profile.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int stalls;
        bit seen;
        @(negedge clk);
        md.valid_i  = 1'b1;
        md.flush_i  = 1'b0;
        md.funct3_i = f3;
        md.op_a_i   = a;
        md.op_b_i   = b;
        exp_q.push_back(exp);
        name_q.push_back(name);
        #1;
        check({name, "_stall_accept"}, {31'b0, md.stall_o}, 32'd1);
        lat    = 0;
        stalls = 1;
        seen   = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            // Drop the request and disturb operands: the unit must have latched them.
            md.valid_i  = 1'b0;
            md.op_a_i   = ~a;
            md.op_b_i   = ~b;
            md.funct3_i = ~f3;
            if (md.done_o === 1'b1) begin
                seen = 1'b1;
            end else if (md.stall_o === 1'b1) begin
                stalls++;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        check({name, "_stall_done"}, {31'b0, md.stall_o}, 32'd0);
        last_result = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        md.valid_i  = 1'b0;
        md.flush_i  = 1'b0;
        md.funct3_i = 3'b000;
        md.op_a_i   = '0;
        md.op_b_i   = '0;
        last_result = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'b0, md.busy_o},  32'd0);
        check("reset_done",   {31'b0, md.done_o},  32'd0);
        check("reset_stall",  {31'b0, md.stall_o}, 32'd0);
        check("reset_result", md.result_o,         32'd0);
        rst = 1'b0;

        // Multiplies
        run_op("mul_7_m3",      F3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulh_min_min",  F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_op("mulhu_max_max", F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulhsu_m1_max", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);

        // Divides
        run_op("div_m7_2",      F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run_op("rem_m7_2",      F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run_op("divu_100_7",    F3_DIVU,   32'd100,       32'd7,         32'd14,        34);
        run_op("remu_100_7",    F3_REMU,   32'd100,       32'd7,         32'd2,         34);

        // Special cases complete one edge after accept
        run_op("div_ovf",       F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",       F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        run_op("divu_by0",      F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_by0",      F3_REMU,   32'd5,         32'd0,         32'd5,         1);

        // Flush in CALC at counter 10: no completion, result unchanged
        @(negedge clk);
        md.valid_i  = 1'b1;
        md.funct3_i = F3_DIV;
        md.op_a_i   = 32'd1000;
        md.op_b_i   = 32'd3;
        @(negedge clk);
        md.valid_i = 1'b0;
        repeat (10) @(negedge clk);
        md.flush_i = 1'b1;
        @(negedge clk);
        md.flush_i = 1'b0;
        #1;
        check("flush_busy",   {31'b0, md.busy_o},  32'd0);
        check("flush_stall",  {31'b0, md.stall_o}, 32'd0);
        check("flush_done",   {31'b0, md.done_o},  32'd0);
        check("flush_result", md.result_o,         last_result);
        repeat (3) @(negedge clk);
        run_op("mul_after_flush", F3_MUL, 32'd3, 32'd4, 32'd12, 34);

        // Reset in CALC at counter 20
        @(negedge clk);
        md.valid_i  = 1'b1;
        md.funct3_i = F3_MUL;
        md.op_a_i   = 32'h1234_5678;
        md.op_b_i   = 32'd9;
        @(negedge clk);
        md.valid_i = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy",   {31'b0, md.busy_o},  32'd0);
        check("midrst_stall",  {31'b0, md.stall_o}, 32'd0);
        check("midrst_done",   {31'b0, md.done_o},  32'd0);
        check("midrst_result", md.result_o,         32'd0);

        // Back-to-back ops, each accepted in the IDLE cycle after the previous DONE
        run_op("b2b_mul_5_6",   F3_MUL,   32'd5,         32'd6,         32'd30,        34);
        run_op("b2b_mulhu",     F3_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1,         34);
        run_op("b2b_mul_ffff",  F3_MUL,   32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 34);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
